// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: hold-vector encodings
// and multi-cycle sequencer state codes.
package pipe_stall_ctrl_pkg;

    localparam int STALL_W = 6;

    // Bit order: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_FIXED = 2'd1,
        MC_VAR   = 2'd2
    } mc_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall controller.
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
);
    logic               stallreq_id;
    logic               mc_start;
    logic               mc_var;
    logic [CNT_W-1:0]   mc_len;
    logic               mc_done;
    logic               mc_cancel;
    logic [STALL_W-1:0] stall_o;
    logic               mc_busy_o;
    logic [CNT_W-1:0]   mc_cnt_o;
    logic               mc_last_o;
    logic               mc_tmo_o;
    logic [PERF_W-1:0]  stall_cnt_o;

    modport master (
        output stallreq_id, mc_start, mc_var, mc_len, mc_done, mc_cancel,
        input  stall_o, mc_busy_o, mc_cnt_o, mc_last_o, mc_tmo_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_id, mc_start, mc_var, mc_len, mc_done, mc_cancel,
        output stall_o, mc_busy_o, mc_cnt_o, mc_last_o, mc_tmo_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module pipe_stall_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (inc && (cnt_reg != '1))
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller for the 5-stage pipeline: merges id/ex stall
// requests into the hold vector and sequences ex-stage multi-cycle ops.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int MAX_CYC = 40,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYC);

    mc_state_t          state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   len_reg, len_next;
    logic               tmo_reg, tmo_next;
    logic               exs;
    logic               last;
    logic [STALL_W-1:0] stall_vec;
    logic [STALL_W-1:0] stall_gated;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= MC_IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
            tmo_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            tmo_reg   <= tmo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        tmo_next   = 1'b0;
        exs        = 1'b0;
        last       = 1'b0;
        case (state_reg)
            MC_IDLE: begin
                exs = bus.mc_start && !bus.mc_cancel && (bus.mc_var || (bus.mc_len != '0));
                if (exs) begin
                    cnt_next = CNT_W'(1);
                    if (bus.mc_var) begin
                        state_next = MC_VAR;
                    end else begin
                        state_next = MC_FIXED;
                        len_next   = bus.mc_len;
                    end
                end
            end
            MC_FIXED: begin
                if (bus.mc_cancel) begin
                    state_next = MC_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == len_reg) begin
                    last       = 1'b1;
                    state_next = MC_IDLE;
                    cnt_next   = '0;
                end else begin
                    exs      = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            MC_VAR: begin
                // Cancel wins over a divider result arriving in the same cycle.
                if (bus.mc_cancel) begin
                    state_next = MC_IDLE;
                    cnt_next   = '0;
                end else if (bus.mc_done) begin
                    last       = 1'b1;
                    state_next = MC_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == MAX_CNT) begin
                    last       = 1'b1;
                    tmo_next   = 1'b1;
                    state_next = MC_IDLE;
                    cnt_next   = '0;
                end else begin
                    exs      = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = MC_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // The ex hold covers every bit the id hold would set, so it takes priority.
    assign stall_vec   = exs ? STALL_EX : (bus.stallreq_id ? STALL_ID : STALL_NONE);
    assign stall_gated = rst ? stall_vec : STALL_NONE;

    assign bus.stall_o   = stall_gated;
    assign bus.mc_last_o = rst && last;
    assign bus.mc_busy_o = rst && (state_reg != MC_IDLE);
    assign bus.mc_cnt_o  = cnt_reg;
    assign bus.mc_tmo_o  = tmo_reg;

    pipe_stall_ctrl_sat_counter #(
        .W (PERF_W)
    ) u_perf (
        .clk (clk),
        .rst (rst),
        .inc (stall_gated != STALL_NONE),
        .cnt (bus.stall_cnt_o)
    );
endmodule
